bit_serializer: RTL and testbench
=================================

// Module: bit_serializer
// PURPOSE
//   Parallel-to-serial stimulus stage driving the X input of SequenceDetector.
//   Accepts a DATA_W-bit word through a LOAD/READY handshake and shifts it out
//   one bit at a time on SOUT, holding each bit for BIT_CYCLES clocks.
//   SVALID qualifies each bit; DONE pulses once when a frame completes.
// PARAMETERS
//   DATA_W      8  word width, >= 2
//   BIT_CYCLES  1  clocks each bit is held on SOUT, >= 1
//   MSB_FIRST   1  1: DIN[DATA_W-1] is sent first; 0: DIN[0] is sent first
// PORTS
//   CLK     in   1       rising-edge clock
//   nRST    in   1       synchronous reset, active low
//   LOAD    in   1       request to start a frame; accepted only when READY=1
//   DIN     in   DATA_W  word, sampled only at the accepting edge
//   READY   out  1       1 when idle and a LOAD will be accepted
//   SOUT    out  1       serial bit (feeds SequenceDetector X)
//   SVALID  out  1       1 while SOUT carries a frame bit
//   DONE    out  1       one-cycle pulse after the last bit period
// BEHAVIOUR
//   Clock/reset: one clock, CLK. nRST is synchronous, active low. It is sampled
//     on the CLK rising edge and overrides all other inputs.
//   Reset values: state=IDLE, READY=1, SOUT=0, SVALID=0, DONE=0; counters=0.
//   FSM: IDLE -> SHIFT -> FINISH -> IDLE.
//     IDLE:   READY=1. LOAD=1 at an edge: latch DIN into the shift register,
//             bit_cnt=0, per_cnt=0, go to SHIFT.
//     SHIFT:  SOUT=current bit, SVALID=1, READY=0. per_cnt counts
//             0..BIT_CYCLES-1. At BIT_CYCLES-1: per_cnt=0, shift, bit_cnt++.
//             When bit_cnt=DATA_W-1 and per_cnt=BIT_CYCLES-1, go to FINISH.
//     FINISH: DONE=1, SVALID=0, SOUT=0, READY=1. LOAD=1 here is accepted
//             (next state SHIFT). Otherwise go to IDLE.
//   Latency: LOAD accepted at edge k -> first bit valid in cycle k+1.
//     SVALID is high for exactly DATA_W*BIT_CYCLES cycles. DONE is in cycle
//     k+1+DATA_W*BIT_CYCLES.
//   Back-to-back: LOAD held high gives a one-cycle SVALID=0 gap (the FINISH
//     cycle) between frames.
//   LOAD while READY=0: ignored, not queued; the frame and DIN copy are unchanged.
//   DIN changes after acceptance have no effect.
//   All outputs are registered or decoded from registered state only; no
//     combinational path from LOAD or DIN to any output.
//   Reset mid-frame: the frame is abandoned. The next cycle shows the reset
//     values; no DONE pulse is generated.
//   Counter widths: bit_cnt is $clog2(DATA_W), per_cnt is $clog2(BIT_CYCLES)
//     (minimum 1 bit). Neither counter wraps past its terminal value.
// TESTING
//   1 Hold nRST=0 for 2 edges with LOAD=1 -> READY=1, SOUT=0, SVALID=0,
//     DONE=0; nothing loaded.
//   2 Defaults, LOAD with DIN=8'hB4 -> SOUT=1,0,1,1,0,1,0,0 over cycles 1-8
//     with SVALID=1; DONE=1 and READY=1 in cycle 9.
//   3 During test 2, pulse LOAD with DIN=8'hFF at bit 3 -> ignored; remaining
//     bits still 1,0,1,0,0.
//   4 BIT_CYCLES=3, DIN=8'hE0 -> each bit held 3 cycles; SVALID high for 24
//     cycles; DONE in cycle 25. A downstream SequenceDetector Y rises during
//     the 1-run.
//   5 LOAD held high, DIN=8'hA5 then 8'h0F at the DONE cycle -> 8 bits, one
//     SVALID=0 gap, then 0,0,0,0,1,1,1,1.
//   6 nRST=0 for 1 edge at bit 4 of 8'hFF -> next cycle READY=1, SVALID=0,
//     SOUT=0; no DONE pulse.
//   7 MSB_FIRST=0, DIN=8'h01 -> SOUT=1,0,0,0,0,0,0,0.

Source files
------------

// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel-to-serial frame stage with LOAD/READY handshake
// Outputs decode from registered state only, so LOAD/DIN never reach an output combinationally.
module bit_serializer #(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 1,
  parameter int MSB_FIRST  = 1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              LOAD,
  input  logic [DATA_W-1:0] DIN,
  output logic              READY,
  output logic              SOUT,
  output logic              SVALID,
  output logic              DONE
);

  localparam int BW = $clog2(DATA_W);
  localparam int PW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  localparam logic [PW-1:0] PER_LAST = PW'(BIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t            state, next_state;
  logic [DATA_W-1:0] sreg, next_sreg;
  logic [BW-1:0]     bit_cnt, next_bit_cnt;
  logic [PW-1:0]     per_cnt, next_per_cnt;
  logic              cur_bit;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state   <= IDLE;
      sreg    <= '0;
      bit_cnt <= '0;
      per_cnt <= '0;
    end else begin
      state   <= next_state;
      sreg    <= next_sreg;
      bit_cnt <= next_bit_cnt;
      per_cnt <= next_per_cnt;
    end
  end

  always_comb begin
    next_state   = state;
    next_sreg    = sreg;
    next_bit_cnt = bit_cnt;
    next_per_cnt = per_cnt;
    case (state)
      IDLE, FINISH: begin
        // FINISH accepts a new word too, giving a single idle cycle between frames
        if (LOAD) begin
          next_state   = SHIFT;
          next_sreg    = DIN;
          next_bit_cnt = '0;
          next_per_cnt = '0;
        end else begin
          next_state = IDLE;
        end
      end
      SHIFT: begin
        if (per_cnt == PER_LAST) begin
          next_per_cnt = '0;
          if (bit_cnt == BIT_LAST) begin
            next_state = FINISH;
          end else begin
            next_bit_cnt = bit_cnt + BW'(1);
            next_sreg    = (MSB_FIRST != 0) ? {sreg[DATA_W-2:0], 1'b0}
                                            : {1'b0, sreg[DATA_W-1:1]};
          end
        end else begin
          next_per_cnt = per_cnt + PW'(1);
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign cur_bit = (MSB_FIRST != 0) ? sreg[DATA_W-1] : sreg[0];
  assign READY   = (state != SHIFT);
  assign SVALID  = (state == SHIFT);
  assign SOUT    = (state == SHIFT) && cur_bit;
  assign DONE    = (state == FINISH);

endmodule

// File: tb/tb_bit_serializer.sv
// tb/tb_bit_serializer.sv - scoreboard bench for bit_serializer
// Three instances cover default, slow-bit and LSB-first builds.
module tb_bit_serializer;

  logic CLK = 1'b0;
  logic nRST;
  logic load_a, load_b, load_c;
  logic [7:0] din_a, din_b, din_c;
  logic ready_a, sout_a, svalid_a, done_a;
  logic ready_b, sout_b, svalid_b, done_b;
  logic ready_c, sout_c, svalid_c, done_c;

  int checks = 0;
  int errors = 0;
  bit q_a[$];
  bit q_b[$];
  bit q_c[$];

  always #5 CLK = ~CLK;

  bit_serializer u_dut_a (
    .CLK(CLK), .nRST(nRST), .LOAD(load_a), .DIN(din_a),
    .READY(ready_a), .SOUT(sout_a), .SVALID(svalid_a), .DONE(done_a)
  );

  bit_serializer #(.DATA_W(8), .BIT_CYCLES(3), .MSB_FIRST(1)) u_dut_b (
    .CLK(CLK), .nRST(nRST), .LOAD(load_b), .DIN(din_b),
    .READY(ready_b), .SOUT(sout_b), .SVALID(svalid_b), .DONE(done_b)
  );

  bit_serializer #(.DATA_W(8), .BIT_CYCLES(1), .MSB_FIRST(0)) u_dut_c (
    .CLK(CLK), .nRST(nRST), .LOAD(load_c), .DIN(din_c),
    .READY(ready_c), .SOUT(sout_c), .SVALID(svalid_c), .DONE(done_c)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic push_a(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) q_a.push_back(d[7-i]);
  endtask

  always @(negedge CLK) begin
    if (svalid_a) begin
      if (q_a.size() == 0) check("a_unexpected_bit", 1, 0);
      else check("a_sout", sout_a, q_a.pop_front());
    end
    if (svalid_b) begin
      if (q_b.size() == 0) check("b_unexpected_bit", 1, 0);
      else check("b_sout", sout_b, q_b.pop_front());
    end
    if (svalid_c) begin
      if (q_c.size() == 0) check("c_unexpected_bit", 1, 0);
      else check("c_sout", sout_c, q_c.pop_front());
    end
  end

  task automatic frame_a(input logic [7:0] d, input int glitch);
    load_a = 1'b1;
    din_a  = d;
    push_a(d, 8);
    tick;
    load_a = 1'b0;
    din_a  = 8'($urandom);
    for (int c = 1; c <= 8; c++) begin
      check("a_svalid_in_frame", svalid_a, 1);
      check("a_ready_busy", ready_a, 0);
      check("a_done_early", done_a, 0);
      if (c == glitch) begin
        load_a = 1'b1;
        din_a  = 8'hFF;
      end
      tick;
      load_a = 1'b0;
    end
    check("a_done", done_a, 1);
    check("a_ready_done", ready_a, 1);
    check("a_svalid_done", svalid_a, 0);
    check("a_sout_done", sout_a, 0);
    check("a_queue_drained", q_a.size(), 0);
    tick;
    check("a_done_once", done_a, 0);
    check("a_idle_svalid", svalid_a, 0);
  endtask

  initial begin
    nRST = 1'b0;
    load_a = 1'b1; din_a = 8'hFF;
    load_b = 1'b1; din_b = 8'hFF;
    load_c = 1'b1; din_c = 8'hFF;
    @(negedge CLK);
    tick;
    tick;
    check("rst_ready", ready_a, 1);
    check("rst_sout", sout_a, 0);
    check("rst_svalid", svalid_a, 0);
    check("rst_done", done_a, 0);
    check("rst_b_ready", ready_b, 1);
    check("rst_c_svalid", svalid_c, 0);
    load_a = 1'b0; load_b = 1'b0; load_c = 1'b0;
    nRST = 1'b1;
    tick;
    check("post_rst_nothing_loaded", svalid_a, 0);

    frame_a(8'hB4, 0);
    frame_a(8'hB4, 4);
    frame_a(8'h5A, 8);

    // back-to-back with LOAD held high
    load_a = 1'b1;
    din_a  = 8'hA5;
    push_a(8'hA5, 8);
    tick;
    for (int c = 1; c <= 7; c++) tick;
    check("b2b_last_bit_valid", svalid_a, 1);
    tick;
    check("b2b_done", done_a, 1);
    check("b2b_gap", svalid_a, 0);
    din_a = 8'h0F;
    push_a(8'h0F, 8);
    tick;
    load_a = 1'b0;
    check("b2b_second_start", svalid_a, 1);
    for (int c = 1; c <= 7; c++) tick;
    tick;
    check("b2b_done2", done_a, 1);
    check("b2b_queue", q_a.size(), 0);
    tick;

    // reset mid-frame
    load_a = 1'b1;
    din_a  = 8'hFF;
    push_a(8'hFF, 5);
    tick;
    load_a = 1'b0;
    for (int c = 1; c <= 4; c++) tick;
    nRST = 1'b0;
    tick;
    nRST = 1'b1;
    check("midrst_ready", ready_a, 1);
    check("midrst_svalid", svalid_a, 0);
    check("midrst_sout", sout_a, 0);
    check("midrst_done", done_a, 0);
    check("midrst_queue", q_a.size(), 0);
    tick;
    check("midrst_no_done", done_a, 0);
    check("midrst_idle", svalid_a, 0);

    // slow bits
    load_b = 1'b1;
    din_b  = 8'hE0;
    for (int i = 0; i < 8; i++) for (int r = 0; r < 3; r++) q_b.push_back(din_b[7-i]);
    tick;
    load_b = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      check("b_svalid", svalid_b, 1);
      check("b_done_early", done_b, 0);
      tick;
    end
    check("b_done", done_b, 1);
    check("b_svalid_end", svalid_b, 0);
    check("b_queue", q_b.size(), 0);
    tick;
    check("b_done_once", done_b, 0);

    // LSB first
    load_c = 1'b1;
    din_c  = 8'h01;
    for (int i = 0; i < 8; i++) q_c.push_back(din_c[i]);
    tick;
    load_c = 1'b0;
    for (int c = 1; c <= 8; c++) tick;
    check("c_done", done_c, 1);
    check("c_queue", q_c.size(), 0);
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
